param_shift_register: RTL and testbench
=======================================

Name: param_shift_register

Overview:
Parametrised successor to the fixed 4-bit reset shift register. It provides WIDTH-bit data over DEPTH stages, with runtime shift direction, parallel load, synchronous clear and a saturating fill counter that flags when the output stage holds valid data. It is used in basic datapath examples and test harnesses as a delay line or serialiser, and is driven through the standard tester interface.

Parameters:
WIDTH, 4, data width per stage in bits; WIDTH >= 1
DEPTH, 4, number of stages; DEPTH >= 2
RESET_VAL, 0, value every stage takes on reset or clear; truncated to WIDTH bits
CNT_W, $clog2(DEPTH+1), width of io_count; derived, not overridden
SEL_W, $clog2(DEPTH), width of io_tap_sel; derived, not overridden

Ports:
clock  input  1  sole clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
io_shift  input  1  shift-enable strobe
io_dir  input  1  0 = forward (in at s[0], out at s[DEPTH-1]); 1 = reverse (in at s[DEPTH-1], out at s[0])
io_in  input  WIDTH  serial data inserted on shift
io_load  input  1  parallel-load strobe
io_load_data  input  DEPTH*WIDTH  stage i loads bits [i*WIDTH +: WIDTH]
io_clear  input  1  synchronous clear
io_tap_sel  input  SEL_W  tap stage index (used only with the optional feature)
io_out  output  WIDTH  output-end stage: s[DEPTH-1] when io_dir=0, s[0] when io_dir=1
io_tap_out  output  WIDTH  selected stage (optional feature)
io_count  output  CNT_W  number of valid stages, saturating at DEPTH
io_full  output  1  io_count == DEPTH

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately, including mid-operation): all stages = RESET_VAL, io_count = 0, io_full = 0. Therefore io_out = RESET_VAL and io_tap_out = RESET_VAL with the macro, 0 without.
- Per rising edge, priority is clear > load > shift > hold.
  - io_clear = 1: all stages = RESET_VAL; count = 0.
  - Else io_load = 1: s[i] = io_load_data slice i; count = DEPTH.
  - Else io_shift = 1 with io_dir = 0: s[0] = io_in; s[i] = s[i-1] for i >= 1.
  - Else io_shift = 1 with io_dir = 1: s[DEPTH-1] = io_in; s[i] = s[i+1] for i < DEPTH-1.
  - On either shift: count = min(count+1, DEPTH). No wrap-around; a full register keeps count = DEPTH.
  - Else: hold all state.
- io_out is a combinational mux of registered stages selected by io_dir. There is no combinational path from io_in to io_out. Changing io_dir alters io_out in the same cycle without altering stage contents.
- Latency: a value shifted in appears at io_out after DEPTH shift edges in a constant direction.
- io_count tracks shifts, not data validity, across direction changes.
- Simultaneous io_clear and io_load or io_shift: clear wins and the other inputs are ignored.
- io_load_data is ignored unless io_load = 1.

Optional Feature:
PARAM_SHIFT_REG_TAP_EN
- Defined: io_tap_out = s[io_tap_sel] combinationally. If io_tap_sel >= DEPTH (non-power-of-two DEPTH), io_tap_out = 0.
- Undefined: io_tap_out is tied to 0 and io_tap_sel is unused. The port list is identical in both builds.

Decomposition:
- Package shift_reg_pkg holds:
  - DIR_FWD = 1'b0 and DIR_REV = 1'b1
  - a count-width function clog2
  - an enumerated op type (OP_HOLD, OP_SHIFT, OP_LOAD, OP_CLEAR) for the priority decode
- One sub-module, shift_reg_stage: a single WIDTH-bit register with async reset to RESET_VAL and a 4-way next-value mux (hold / left neighbour / right neighbour / load), instantiated DEPTH times by generate. End stages take io_in as the neighbour input.

Test Plan:
1. Reset and mid-shift reset (WIDTH=4, DEPTH=4): assert reset → io_out=0, io_count=0, io_full=0. Assert reset asynchronously between edges after 2 shifts → outputs return to 0 before the next edge.
2. Forward fill: dir=0, shift in 1,2,3,4 → io_out=1 and io_full=1 after the 4th edge. Shift in 5 → io_out=2, io_count stays 4.
3. Hold: shift=0 for 3 cycles with io_in toggling → io_out, io_count and all stages unchanged.
4. Load then reverse: load io_load_data=16'h4321, dir=1 → io_out=1 (s[0]), io_count=4. Shift in 4'hA → io_out=2 and s[3]=A.
5. Priority: clear=1, load=1, shift=1 in the same cycle after a fill → all stages=RESET_VAL, io_count=0, io_full=0. Repeat with RESET_VAL=4'hF → io_out=F.
6. Tap (macro defined): after test 4's load, tap_sel=2 → io_tap_out=3. With DEPTH=5, tap_sel=6 → io_tap_out=0. Macro undefined: io_tap_out=0 for all tap_sel.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the parameterised shift register: shift direction
// encodings, a constant-capable ceil(log2) helper and the per-edge operation
// type produced by the priority decode (clear > load > shift > hold).
package shift_reg_pkg;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_REV = 1'b1;

   typedef enum logic [1:0] {
      OP_HOLD  = 2'd0,
      OP_SHIFT = 2'd1,
      OP_LOAD  = 2'd2,
      OP_CLEAR = 2'd3
   } op_e;

   // ceil(log2(value)); usable in parameter defaults
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/shift_reg_stage.sv
// One WIDTH-bit stage of the shift register. The next value is chosen from
// hold / left neighbour (forward shift) / right neighbour (reverse shift) /
// parallel-load slice, with clear forcing the reset value.
module shift_reg_stage
   import shift_reg_pkg::*;
#(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  op_e              op_i,
   input  logic             dir_i,
   input  logic [WIDTH-1:0] left_i,
   input  logic [WIDTH-1:0] right_i,
   input  logic [WIDTH-1:0] load_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   // Next-value select for this stage
   always_comb begin
      data_d = data_q;
      case (op_i)
         OP_CLEAR: data_d = RESET_VAL;
         OP_LOAD:  data_d = load_i;
         OP_SHIFT: data_d = (dir_i == DIR_FWD) ? left_i : right_i;
         default:  data_d = data_q;
      endcase
   end

   // Stage register with asynchronous reset to the reset value
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_q <= RESET_VAL;
      end else begin
         data_q <= data_d;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/param_shift_register.sv
// Parameterised shift register: DEPTH stages of WIDTH bits, runtime shift
// direction, parallel load, synchronous clear and a saturating fill counter.
// Optional feature macro: PARAM_SHIFT_REG_TAP_EN enables io_tap_out as a
// combinational read of stage io_tap_sel; otherwise io_tap_out is 0.
module param_shift_register
   import shift_reg_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int DEPTH     = 4,
   parameter int RESET_VAL = 0,
   parameter int CNT_W     = clog2(DEPTH + 1),
   parameter int SEL_W     = clog2(DEPTH)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   io_shift,
   input  logic                   io_dir,
   input  logic [WIDTH-1:0]       io_in,
   input  logic                   io_load,
   input  logic [DEPTH*WIDTH-1:0] io_load_data,
   input  logic                   io_clear,
   input  logic [SEL_W-1:0]       io_tap_sel,
   output logic [WIDTH-1:0]       io_out,
   output logic [WIDTH-1:0]       io_tap_out,
   output logic [CNT_W-1:0]       io_count,
   output logic                   io_full
);

   localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VAL);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   op_e              op_sel;
   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Priority decode of the control strobes: clear > load > shift > hold
   always_comb begin
      op_sel = OP_HOLD;
      if (io_clear) begin
         op_sel = OP_CLEAR;
      end else if (io_load) begin
         op_sel = OP_LOAD;
      end else if (io_shift) begin
         op_sel = OP_SHIFT;
      end
   end

   // Stage chain; the end stages take io_in as their missing neighbour
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] left_nb;
      logic [WIDTH-1:0] right_nb;

      if (gi == 0) begin : g_left_in
         assign left_nb = io_in;
      end else begin : g_left_nb
         assign left_nb = stage_q[gi-1];
      end

      if (gi == DEPTH - 1) begin : g_right_in
         assign right_nb = io_in;
      end else begin : g_right_nb
         assign right_nb = stage_q[gi+1];
      end

      shift_reg_stage #(
         .WIDTH    (WIDTH),
         .RESET_VAL(RST_V)
      ) u_stage (
         .clk_i  (clock),
         .rst_i  (reset),
         .op_i   (op_sel),
         .dir_i  (io_dir),
         .left_i (left_nb),
         .right_i(right_nb),
         .load_i (io_load_data[gi*WIDTH +: WIDTH]),
         .q_o    (stage_q[gi])
      );
   end

   // Fill counter: counts shifts and saturates at DEPTH, no wrap-around
   always_comb begin
      count_d = count_q;
      case (op_sel)
         OP_CLEAR: count_d = '0;
         OP_LOAD:  count_d = DEPTH_C;
         OP_SHIFT: begin
            if (count_q != DEPTH_C) begin
               count_d = count_q + 1'b1;
            end
         end
         default:  count_d = count_q;
      endcase
   end

   // Fill counter register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Output end follows io_dir without touching stage contents
   assign io_out   = (io_dir == DIR_REV) ? stage_q[0] : stage_q[DEPTH-1];
   assign io_count = count_q;
   assign io_full  = (count_q == DEPTH_C);

`ifdef PARAM_SHIFT_REG_TAP_EN
   // Tap read; indices past the last stage (non-power-of-two DEPTH) read 0
   always_comb begin
      io_tap_out = '0;
      if (int'(io_tap_sel) < DEPTH) begin
         io_tap_out = stage_q[io_tap_sel];
      end
   end
`else
   logic unused_tap_sel;
   assign unused_tap_sel = ^io_tap_sel;
   assign io_tap_out     = '0;
`endif

endmodule

// File: tb/tb_param_shift_register.sv
// Bench for param_shift_register: three instances (default, RESET_VAL=F,
// DEPTH=5) share control strobes. Directed table, hand-written corner
// sequences and randomized traffic checked against a queue-based model.
module tb_param_shift_register;

   typedef logic [3:0] nib_q_t[$];

   typedef struct {
      logic        clr;
      logic        ld;
      logic        sh;
      logic        dir;
      logic [3:0]  din;
      logic [15:0] ldd;
      logic [1:0]  sel;
      logic [3:0]  e_out;
      int          e_cnt;
      logic        e_full;
      logic [3:0]  e_tap;
   } vec_t;

   logic        clock;
   logic        reset;
   logic        io_shift;
   logic        io_dir;
   logic [3:0]  io_in;
   logic        io_load;
   logic [15:0] ld4;
   logic [19:0] ld5;
   logic        io_clear;
   logic [1:0]  sel4;
   logic [2:0]  sel5;

   logic [3:0]  out0, out1, out2;
   logic [3:0]  tap0, tap1, tap2;
   logic [2:0]  cnt0, cnt1, cnt2;
   logic        full0, full1, full2;

   int n_checks;
   int n_errors;

   nib_q_t mq0, mq1, mq2;
   int     mc0, mc1, mc2;

   param_shift_register #(.WIDTH(4), .DEPTH(4), .RESET_VAL(0)) u0 (
      .clock(clock), .reset(reset), .io_shift(io_shift), .io_dir(io_dir),
      .io_in(io_in), .io_load(io_load), .io_load_data(ld4), .io_clear(io_clear),
      .io_tap_sel(sel4), .io_out(out0), .io_tap_out(tap0), .io_count(cnt0),
      .io_full(full0)
   );

   param_shift_register #(.WIDTH(4), .DEPTH(4), .RESET_VAL(15)) u1 (
      .clock(clock), .reset(reset), .io_shift(io_shift), .io_dir(io_dir),
      .io_in(io_in), .io_load(io_load), .io_load_data(ld4), .io_clear(io_clear),
      .io_tap_sel(sel4), .io_out(out1), .io_tap_out(tap1), .io_count(cnt1),
      .io_full(full1)
   );

   param_shift_register #(.WIDTH(4), .DEPTH(5), .RESET_VAL(0)) u2 (
      .clock(clock), .reset(reset), .io_shift(io_shift), .io_dir(io_dir),
      .io_in(io_in), .io_load(io_load), .io_load_data(ld5), .io_clear(io_clear),
      .io_tap_sel(sel5), .io_out(out2), .io_tap_out(tap2), .io_count(cnt2),
      .io_full(full2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: q[i] is stage i
   function automatic nib_q_t next_q(nib_q_t q, int depth, logic [3:0] rv, logic [19:0] ld);
      nib_q_t r;
      r = q;
      if (io_clear) begin
         r.delete();
         for (int i = 0; i < depth; i++) r.push_back(rv);
      end else if (io_load) begin
         r.delete();
         for (int i = 0; i < depth; i++) r.push_back(ld[4*i +: 4]);
      end else if (io_shift) begin
         if (io_dir == 1'b0) begin
            r.push_front(io_in);
            void'(r.pop_back());
         end else begin
            void'(r.pop_front());
            r.push_back(io_in);
         end
      end
      return r;
   endfunction

   function automatic int next_cnt(int c, int depth);
      if (io_clear) return 0;
      if (io_load) return depth;
      if (io_shift) return (c + 1 > depth) ? depth : c + 1;
      return c;
   endfunction

   function automatic logic [3:0] exp_tap(nib_q_t q, int depth, int sel);
`ifdef PARAM_SHIFT_REG_TAP_EN
      return (sel < depth) ? q[sel] : 4'h0;
`else
      return 4'h0;
`endif
   endfunction

   task automatic model_reset();
      mq0.delete(); mq1.delete(); mq2.delete();
      for (int i = 0; i < 4; i++) begin
         mq0.push_back(4'h0);
         mq1.push_back(4'hF);
      end
      for (int i = 0; i < 5; i++) mq2.push_back(4'h0);
      mc0 = 0; mc1 = 0; mc2 = 0;
   endtask

   task automatic model_update();
      mq0 = next_q(mq0, 4, 4'h0, {4'h0, ld4});
      mq1 = next_q(mq1, 4, 4'hF, {4'h0, ld4});
      mq2 = next_q(mq2, 5, 4'h0, ld5);
      mc0 = next_cnt(mc0, 4);
      mc1 = next_cnt(mc1, 4);
      mc2 = next_cnt(mc2, 5);
   endtask

   task automatic step();
      @(posedge clock);
      model_update();
      #1;
   endtask

   task automatic chk_all(input string tag);
      chk({tag, "/u0.out"},  32'(out0),  32'(io_dir ? mq0[0] : mq0[3]));
      chk({tag, "/u0.cnt"},  32'(cnt0),  32'(mc0));
      chk({tag, "/u0.full"}, 32'(full0), 32'(mc0 == 4));
      chk({tag, "/u0.tap"},  32'(tap0),  32'(exp_tap(mq0, 4, int'(sel4))));
      chk({tag, "/u1.out"},  32'(out1),  32'(io_dir ? mq1[0] : mq1[3]));
      chk({tag, "/u1.cnt"},  32'(cnt1),  32'(mc1));
      chk({tag, "/u1.full"}, 32'(full1), 32'(mc1 == 4));
      chk({tag, "/u1.tap"},  32'(tap1),  32'(exp_tap(mq1, 4, int'(sel4))));
      chk({tag, "/u2.out"},  32'(out2),  32'(io_dir ? mq2[0] : mq2[4]));
      chk({tag, "/u2.cnt"},  32'(cnt2),  32'(mc2));
      chk({tag, "/u2.full"}, 32'(full2), 32'(mc2 == 5));
      chk({tag, "/u2.tap"},  32'(tap2),  32'(exp_tap(mq2, 5, int'(sel5))));
   endtask

   function automatic vec_t mk(logic clr, logic ld, logic sh, logic dir, logic [3:0] din,
                               logic [15:0] ldd, logic [1:0] sel, logic [3:0] e_out,
                               int e_cnt, logic e_full, logic [3:0] e_tap);
      vec_t v;
      v.clr = clr; v.ld = ld; v.sh = sh; v.dir = dir; v.din = din; v.ldd = ldd;
      v.sel = sel; v.e_out = e_out; v.e_cnt = e_cnt; v.e_full = e_full; v.e_tap = e_tap;
      return v;
   endfunction

   vec_t tbl [14];

   initial begin
      logic [3:0] tap_exp;
      n_checks = 0;
      n_errors = 0;

      tbl[0]  = mk(0, 0, 1, 0, 4'h1, 16'h0000, 2'd0, 4'h0, 1, 0, 4'h1);
      tbl[1]  = mk(0, 0, 1, 0, 4'h2, 16'h0000, 2'd1, 4'h0, 2, 0, 4'h1);
      tbl[2]  = mk(0, 0, 1, 0, 4'h3, 16'h0000, 2'd2, 4'h0, 3, 0, 4'h1);
      tbl[3]  = mk(0, 0, 1, 0, 4'h4, 16'h0000, 2'd3, 4'h1, 4, 1, 4'h1);
      tbl[4]  = mk(0, 0, 1, 0, 4'h5, 16'h0000, 2'd3, 4'h2, 4, 1, 4'h2);
      tbl[5]  = mk(0, 0, 0, 0, 4'hF, 16'hFFFF, 2'd0, 4'h2, 4, 1, 4'h5);
      tbl[6]  = mk(0, 0, 0, 0, 4'h0, 16'h0000, 2'd1, 4'h2, 4, 1, 4'h4);
      tbl[7]  = mk(0, 0, 0, 0, 4'hF, 16'h0000, 2'd2, 4'h2, 4, 1, 4'h3);
      tbl[8]  = mk(0, 0, 0, 1, 4'h0, 16'h0000, 2'd3, 4'h5, 4, 1, 4'h2);
      tbl[9]  = mk(0, 1, 0, 1, 4'h0, 16'h4321, 2'd2, 4'h1, 4, 1, 4'h3);
      tbl[10] = mk(0, 0, 1, 1, 4'hA, 16'h0000, 2'd3, 4'h2, 4, 1, 4'hA);
      tbl[11] = mk(1, 1, 1, 1, 4'hF, 16'hFFFF, 2'd1, 4'h0, 0, 0, 4'h0);
      tbl[12] = mk(0, 0, 1, 1, 4'h7, 16'h0000, 2'd3, 4'h0, 1, 0, 4'h7);
      tbl[13] = mk(0, 0, 0, 0, 4'h0, 16'h1234, 2'd3, 4'h7, 1, 0, 4'h7);

      // Initial reset; outputs checked while reset is still asserted
      reset = 1'b1;
      io_shift = 1'b0; io_dir = 1'b0; io_in = 4'h0; io_load = 1'b0;
      ld4 = '0; ld5 = '0; io_clear = 1'b0; sel4 = 2'd0; sel5 = 3'd0;
      model_reset();
      #12;
      chk("rst/u0.out",  32'(out0),  32'h0);
      chk("rst/u0.cnt",  32'(cnt0),  32'h0);
      chk("rst/u0.full", 32'(full0), 32'h0);
      chk("rst/u1.out",  32'(out1),  32'hF);
      chk_all("rst");
      #1 reset = 1'b0;
      @(negedge clock);

      // Directed table on u0 (models follow along for u1/u2)
      for (int r = 0; r < 14; r++) begin
         io_clear = tbl[r].clr; io_load = tbl[r].ld; io_shift = tbl[r].sh;
         io_dir = tbl[r].dir; io_in = tbl[r].din; ld4 = tbl[r].ldd; sel4 = tbl[r].sel;
         step();
`ifdef PARAM_SHIFT_REG_TAP_EN
         tap_exp = tbl[r].e_tap;
`else
         tap_exp = 4'h0;
`endif
         $display("vec %0d: out=%0h cnt=%0d full=%0b tap=%0h", r, out0, cnt0, full0, tap0);
         chk($sformatf("vec%0d.out", r),  32'(out0),  32'(tbl[r].e_out));
         chk($sformatf("vec%0d.cnt", r),  32'(cnt0),  32'(tbl[r].e_cnt));
         chk($sformatf("vec%0d.full", r), 32'(full0), 32'(tbl[r].e_full));
         chk($sformatf("vec%0d.tap", r),  32'(tap0),  32'(tap_exp));
         chk_all($sformatf("vec%0d", r));
      end

      // Mid-operation asynchronous reset between clock edges
      io_clear = 1'b0; io_load = 1'b0; io_shift = 1'b1; io_dir = 1'b0; io_in = 4'h9;
      step();
      io_in = 4'h6;
      step();
      io_shift = 1'b0; io_dir = 1'b1;
      #1;
      chk("mid/pre.out", 32'(out0), 32'h6);
      chk("mid/pre.cnt", 32'(cnt0), 32'h3);
      #1 reset = 1'b1;
      model_reset();
      #1;
      $display("async reset: out0=%0h cnt0=%0d out1=%0h", out0, cnt0, out1);
      chk("mid/u0.out",  32'(out0),  32'h0);
      chk("mid/u0.cnt",  32'(cnt0),  32'h0);
      chk("mid/u0.full", 32'(full0), 32'h0);
      chk("mid/u1.out",  32'(out1),  32'hF);
      chk_all("mid");
      #1 reset = 1'b0;

      // Fill then clear+load+shift together on the RESET_VAL=F instance
      io_dir = 1'b0; io_shift = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         io_in = 4'(i);
         step();
      end
      chk("fill/u1.out",  32'(out1),  32'h1);
      chk("fill/u1.full", 32'(full1), 32'h1);
      io_clear = 1'b1; io_load = 1'b1; ld4 = 16'h1234; io_in = 4'h3;
      step();
      $display("clear prio: out1=%0h cnt1=%0d full1=%0b", out1, cnt1, full1);
      chk("prio/u1.out",  32'(out1),  32'hF);
      chk("prio/u1.cnt",  32'(cnt1),  32'h0);
      chk("prio/u1.full", 32'(full1), 32'h0);
      chk_all("prio");

      // DEPTH=5 tap, including indices past the last stage
      io_clear = 1'b0; io_load = 1'b1; io_shift = 1'b0; ld5 = 20'h54321; sel5 = 3'd4;
      step();
      io_load = 1'b0;
`ifdef PARAM_SHIFT_REG_TAP_EN
      tap_exp = 4'h5;
`else
      tap_exp = 4'h0;
`endif
      chk("d5/tap4", 32'(tap2), 32'(tap_exp));
      sel5 = 3'd6;
      #1;
      $display("d5 tap sel=6: tap2=%0h", tap2);
      chk("d5/tap6", 32'(tap2), 32'h0);
      chk_all("d5");

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         int r;
         r = int'($urandom_range(0, 15));
         io_clear = (r == 0);
         io_load  = (r == 1 || r == 2);
         io_shift = (r >= 6) || ($urandom_range(0, 3) == 0);
         io_dir   = 1'($urandom_range(0, 1));
         io_in    = 4'($urandom);
         ld4      = 16'($urandom);
         ld5      = 20'($urandom);
         sel4     = 2'($urandom);
         sel5     = 3'($urandom);
         step();
         if (n % 50 == 0) begin
            $display("rnd %0d: out0=%0h cnt0=%0d out2=%0h cnt2=%0d", n, out0, cnt0, out2, cnt2);
         end
         chk_all($sformatf("rnd%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
